// File: rtl/quad_gen.sv
// quad_gen: quadrature step generator.
// sumar/restar pulses adjust a signed count of pending steps. Each committed
// step plays four Gray-coded phases on {a,b}, and each phase is held DIV clocks.
// A new step can start in the same clock that the previous one ends, so
// back-to-back steps leave no idle cycle between them.

module quad_gen #(
    parameter int DIV = 4,
    parameter int CW  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic sumar,
    input  logic restar,
    output logic a,
    output logic b,
    output logic busy,
    output logic step_done,
    output logic ovf
);

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        P4
    } state_t;

    localparam int              TW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0]   T_LOAD = TW'(DIV - 1);
    localparam logic [TW-1:0]   T_ONE  = TW'(1);

    // Two guard bits let pend +/- request +/- commit be computed without wrap.
    localparam int                   XW   = CW + 2;
    localparam logic signed [XW-1:0] ZERO = '0;
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] PMAX = XW'((2 ** (CW - 1)) - 1);
    localparam logic signed [XW-1:0] PMIN = -PMAX - ONE;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   dir_q, dir_d;       // 1 = forward, 0 = reverse
    logic signed [CW-1:0]   pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic                   a_q, a_d;
    logic                   b_q, b_d;

    logic                   phase_end;
    logic                   step_end;
    logic                   start;
    logic signed [XW-1:0]   pend_x;
    logic signed [XW-1:0]   req_v;
    logic signed [XW-1:0]   commit_v;
    logic signed [XW-1:0]   sum_v;
    logic signed [XW-1:0]   keep_v;

    assign phase_end = (timer_q == '0);
    assign step_end  = (state_q == P4) && phase_end;
    // A step is committed from IDLE, or in the last clock of P4 so that the
    // next step follows without a gap.
    assign start     = ((state_q == IDLE) || step_end) && (pend_q != '0);

    // Phase sequencing, step commit and the pending-count update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d  = state_q;
        timer_d  = timer_q;
        dir_d    = dir_q;
        commit_v = ZERO;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        a_d      = 1'b0;
        b_d      = 1'b0;

        if (start) begin
            state_d  = P1;
            timer_d  = T_LOAD;
            dir_d    = ~pend_q[CW-1];
            commit_v = pend_q[CW-1] ? -ONE : ONE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                P1, P2, P3: begin
                    if (phase_end) begin
                        state_d = (state_q == P1) ? P2 : (state_q == P2) ? P3 : P4;
                        timer_d = T_LOAD;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                P4: begin
                    if (phase_end) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - T_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // Simultaneous sumar and restar cancel. A request that would push pend
        // out of range is dropped, but the commit is still applied.
        pend_x = {{2{pend_q[CW-1]}}, pend_q};
        if (sumar && !restar) begin
            req_v = ONE;
        end else if (restar && !sumar) begin
            req_v = -ONE;
        end else begin
            req_v = ZERO;
        end
        sum_v  = pend_x + req_v - commit_v;
        keep_v = pend_x - commit_v;
        if ((sum_v > PMAX) || (sum_v < PMIN)) begin
            pend_d = keep_v[CW-1:0];
            ovf_d  = 1'b1;
        end else begin
            pend_d = sum_v[CW-1:0];
        end

        // Channel levels for the phase being entered. Both directions pass
        // through 11 and end in 00, so each edge changes exactly one channel.
        case (state_d)
            P1:      {a_d, b_d} = dir_d ? 2'b10 : 2'b01;
            P2:      {a_d, b_d} = 2'b11;
            P3:      {a_d, b_d} = dir_d ? 2'b01 : 2'b10;
            default: {a_d, b_d} = 2'b00;
        endcase
    end

    // State registers. Reset is asynchronous and aborts any step in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            dir_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples
            // its pre-edge value regardless of statement order.
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != IDLE) || (pend_q != '0);
    assign step_done = step_end;

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: self-checking bench for quad_gen.
// Three instances are used: DIV=4 for the directed and random cases, DIV=64
// for saturation, and DIV=2 for loopback through a quadrature decoder. Each
// instance has a clock-level reference model that pushes the expected
// {a,b,busy,step_done,ovf} into a queue on every rising edge. A monitor pops
// that queue on every falling edge and compares it with the DUT outputs.

module tb_quad_gen;

    localparam int CW = 8;

    logic clk;
    logic rst;
    logic s_in    [3];
    logic r_in    [3];
    logic a_out   [3];
    logic b_out   [3];
    logic busy_out[3];
    logic done_out[3];
    logic ovf_out [3];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt[3];
    bit dec_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Levels of the quadrature channels for a given phase and direction.
    function automatic logic [1:0] ab_of(input int phase, input bit fwd);
        case (phase)
            1:       return fwd ? 2'b10 : 2'b01;
            2:       return 2'b11;
            3:       return fwd ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Position of a channel pair along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int DIVG = (g == 0) ? 4 : (g == 1) ? 64 : 2;

        logic [4:0] exp_q[$];

        quad_gen #(.DIV(DIVG), .CW(CW)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .sumar    (s_in[g]),
            .restar   (r_in[g]),
            .a        (a_out[g]),
            .b        (b_out[g]),
            .busy     (busy_out[g]),
            .step_done(done_out[g]),
            .ovf      (ovf_out[g])
        );

        // Reference model. pend is a plain integer. A step runs as phases 1..4,
        // and left counts the clocks remaining in the current phase.
        initial begin : model
            int pend_m, phase_m, left_m, commit_m, req_m, nxt_m;
            bit dir_m, ovf_m;
            pend_m = 0; phase_m = 0; left_m = 0; dir_m = 0; ovf_m = 0;
            forever begin
                @(posedge clk);
                if (!rst) begin
                    pend_m = 0; phase_m = 0; left_m = 0; dir_m = 0; ovf_m = 0;
                end else begin
                    commit_m = 0;
                    if (phase_m == 0) begin
                        if (pend_m != 0) begin
                            dir_m = (pend_m > 0); phase_m = 1; left_m = DIVG;
                            commit_m = dir_m ? 1 : -1;
                        end
                    end else begin
                        left_m--;
                        if (left_m == 0) begin
                            if (phase_m < 4) begin
                                phase_m++; left_m = DIVG;
                            end else if (pend_m != 0) begin
                                dir_m = (pend_m > 0); phase_m = 1; left_m = DIVG;
                                commit_m = dir_m ? 1 : -1;
                            end else begin
                                phase_m = 0;
                            end
                        end
                    end
                    req_m = int'(s_in[g]) - int'(r_in[g]);
                    nxt_m = pend_m + req_m - commit_m;
                    if (nxt_m > (2 ** (CW - 1)) - 1 || nxt_m < -(2 ** (CW - 1))) begin
                        pend_m = pend_m - commit_m;
                        ovf_m  = 1'b1;
                    end else begin
                        pend_m = nxt_m;
                    end
                end
                exp_q.push_back({ab_of(phase_m, dir_m),
                                 (phase_m != 0) || (pend_m != 0),
                                 (phase_m == 4) && (left_m == 1),
                                 ovf_m});
            end
        end

        // Monitor: one expected record per clock, compared on the falling edge.
        initial begin : monitor
            logic [4:0] exp_v, act_v;
            logic [1:0] prev_ab, cur_ab;
            prev_ab = 2'b00;
            forever begin
                @(negedge clk);
                cur_ab = {a_out[g], b_out[g]};
                act_v  = {cur_ab, busy_out[g], done_out[g], ovf_out[g]};
                if (exp_q.size() == 0) begin
                    check($sformatf("sb%0d_empty", g), 32'd0, 32'd1);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (rst) begin
                        check($sformatf("sb%0d_outputs", g), act_v, exp_v);
                        check($sformatf("sb%0d_gray", g), ($countones(prev_ab ^ cur_ab) <= 1), 1);
                    end
                end
                if (rst && done_out[g]) done_cnt[g]++;
                prev_ab = cur_ab;
            end
        end
    end

    // Loopback decoder on the DIV=2 instance. It turns four quarter-steps in
    // one direction into one decoded sumar (1) or restar (0).
    initial begin : decoder
        logic [1:0] prev_ab, cur_ab;
        int q, d;
        prev_ab = 2'b00; q = 0;
        forever begin
            @(negedge clk);
            cur_ab = {a_out[2], b_out[2]};
            if (!rst) begin
                q = 0;
            end else if (cur_ab != prev_ab) begin
                d = (pos_of(cur_ab) - pos_of(prev_ab) + 4) % 4;
                check("dec_legal_transition", (d != 2), 1);
                if (d == 1) q++;
                else if (d == 3) q--;
                if (q == 4) begin dec_q.push_back(1'b1); q = 0; end
                if (q == -4) begin dec_q.push_back(1'b0); q = 0; end
            end
            prev_ab = cur_ab;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply(input int g, input logic s, input logic r);
        @(negedge clk);
        s_in[g] = s;
        r_in[g] = r;
    endtask

    task automatic wait_idle(input int g, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = !busy_out[g];
        end
        check({name, "_reaches_idle"}, seen, 1);
    endtask

    initial begin : stimulus
        logic [1:0] fwd_tab[4];
        logic [1:0] first_rev;
        bit         dirs[20];
        bit         tmp, found;
        int         base, cnt, nf, nr, j;

        fwd_tab[0] = 2'b10; fwd_tab[1] = 2'b11; fwd_tab[2] = 2'b01; fwd_tab[3] = 2'b00;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            s_in[g] = 1'b0; r_in[g] = 1'b0; done_cnt[g] = 0;
        end

        // Reset state.
        @(negedge clk); #1;
        for (int g = 0; g < 3; g++)
            check($sformatf("reset_state%0d", g),
                  {a_out[g], b_out[g], busy_out[g], done_out[g], ovf_out[g]}, 5'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // With no request, the instance stays idle after reset is released.
        repeat (3) @(negedge clk);
        check("post_reset_idle", {a_out[0], b_out[0], busy_out[0]}, 3'b000);

        // One forward step, DIV=4: 10,11,01,00 held 4 clocks each, 2-edge latency.
        apply(0, 1'b1, 1'b0);
        apply(0, 1'b0, 1'b0);
        check("fwd_latency_ab", {a_out[0], b_out[0], busy_out[0]}, 3'b001);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("fwd_clk%0d", i),
                  {a_out[0], b_out[0], busy_out[0], done_out[0]},
                  {fwd_tab[i / 4], 1'b1, (i == 15)});
        end
        @(negedge clk);
        check("fwd_end", {a_out[0], b_out[0], busy_out[0], done_out[0]}, 4'b0000);

        // sumar and restar in the same cycle cancel each other.
        apply(0, 1'b1, 1'b1);
        apply(0, 1'b0, 1'b0);
        check("both_cancel_a", {a_out[0], b_out[0], busy_out[0], ovf_out[0]}, 4'b0000);
        @(negedge clk);
        check("both_cancel_b", {a_out[0], b_out[0], busy_out[0], ovf_out[0]}, 4'b0000);

        // Three restar pulses give three reverse steps with no gap between them.
        // busy covers 1 latency clock (pend only) plus 3 x 16 step clocks.
        base = done_cnt[0]; cnt = 0; first_rev = 2'b00;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (busy_out[0]) cnt++;
            if (i == 2) first_rev = {a_out[0], b_out[0]};
            r_in[0] = (i < 3);
        end
        check("rev3_first_phase", first_rev, 2'b01);
        check("rev3_busy_clocks", cnt, 49);
        check("rev3_done_pulses", done_cnt[0] - base, 3);

        // Random traffic on the DIV=4 instance, checked by the scoreboard.
        for (int i = 0; i < 80; i++)
            apply(0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        apply(0, 1'b0, 1'b0);
        wait_idle(0, 2000, "random");

        // Reset in the middle of P2 aborts the step.
        apply(0, 1'b1, 1'b0);
        apply(0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = ({a_out[0], b_out[0]} == 2'b11);
        end
        check("midstep_reach_p2", found, 1);
        base = done_cnt[0];
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("midstep_reset_outputs",
                 {a_out[0], b_out[0], busy_out[0], done_out[0], ovf_out[0]}, 5'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        check("midstep_no_done", done_cnt[0] - base, 0);
        check("midstep_no_residual", {a_out[0], b_out[0], busy_out[0]}, 3'b000);

        // Saturation, DIV=64: 140 sumar pulses give pend 127, ovf, and 128 steps.
        base = done_cnt[1];
        for (int i = 0; i < 140; i++) apply(1, 1'b1, 1'b0);
        apply(1, 1'b0, 1'b0);
        check("sat_ovf_set", ovf_out[1], 1);
        wait_idle(1, 34000, "sat");
        check("sat_step_count", done_cnt[1] - base, 128);
        check("sat_ovf_sticky", ovf_out[1], 1);

        // Loopback, DIV=2: 20 shuffled pulses (13 sumar, 7 restar), each
        // allowed to complete, must decode as the same sequence.
        for (int i = 0; i < 20; i++) dirs[i] = (i < 13);
        for (int i = 19; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = dirs[i]; dirs[i] = dirs[j]; dirs[j] = tmp;
        end
        dec_q.delete();
        for (int i = 0; i < 20; i++) begin
            apply(2, dirs[i], !dirs[i]);
            apply(2, 1'b0, 1'b0);
            wait_idle(2, 40, $sformatf("loop%0d", i));
        end
        repeat (2) @(negedge clk);
        check("loop_decoded_count", dec_q.size(), 20);
        nf = 0; nr = 0;
        for (int i = 0; i < dec_q.size(); i++) begin
            if (dec_q[i]) nf++; else nr++;
            if (i < 20) check($sformatf("loop_order%0d", i), dec_q[i], dirs[i]);
        end
        check("loop_sumar_count", nf, 13);
        check("loop_restar_count", nr, 7);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
